// File: rtl/data_extractor_stream_pkg.sv
// Shared types and helpers for the AXI-Stream header extractor.
//   ext_state_e         : extractor FSM states (awaiting header beat / payload / residue flush)
//   keep_to_count       : number of set bits in a tkeep vector
//   count_to_msb_mask   : tkeep vector of a given width with the top 'cnt' lanes set
package data_extractor_stream_pkg;

  typedef enum logic [1:0] {
    StHdr   = 2'd0,
    StBody  = 2'd1,
    StFlush = 2'd2
  } ext_state_e;

  // Helpers operate on a fixed-width container so any DATA_BYTE_WD up to this fits.
  localparam int unsigned MaxKeepWd = 64;

  function automatic int unsigned keep_to_count(input logic [MaxKeepWd-1:0] keep);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < MaxKeepWd; i++) begin
      if (keep[i]) cnt++;
    end
    return cnt;
  endfunction

  function automatic logic [MaxKeepWd-1:0] count_to_msb_mask(input int unsigned cnt,
                                                             input int unsigned width);
    logic [MaxKeepWd-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MaxKeepWd; i++) begin
      if ((i < width) && (i + cnt >= width)) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/axis_byte_merge.sv
// Combinational residue + beat byte shifter.
// The residue occupies the top shift_i byte lanes of res_*_i (MSB-aligned, zero below).
// The incoming beat is shifted down by shift_i bytes and ORed under the residue:
//   merged_*_o : upper half of the concatenation -> one output beat
//   rem_*_o    : lower half -> beat bytes that did not fit, MSB-aligned (new residue)
// With a zero residue this doubles as the header splitter: the top (W-shift_i) beat bytes
// land right-justified in merged_*_o.
// Ports:
//   res_data_i/res_keep_i   residue bytes and lane mask
//   beat_data_i/beat_keep_i incoming beat (keep MSB-aligned)
//   shift_i                 residue width in bytes (0..ByteWd)
//   merged_data_o/keep_o    combined full-width beat
//   rem_data_o/keep_o       leftover bytes for the next residue
module axis_byte_merge
  import data_extractor_stream_pkg::*;
#(
  parameter int unsigned DataWd = 32,
  parameter int unsigned ByteWd = DataWd / 8,
  parameter int unsigned ShWd   = $clog2(ByteWd) + 1
) (
  input  logic [DataWd-1:0] res_data_i,
  input  logic [ByteWd-1:0] res_keep_i,
  input  logic [DataWd-1:0] beat_data_i,
  input  logic [ByteWd-1:0] beat_keep_i,
  input  logic [ShWd-1:0]   shift_i,
  output logic [DataWd-1:0] merged_data_o,
  output logic [ByteWd-1:0] merged_keep_o,
  output logic [DataWd-1:0] rem_data_o,
  output logic [ByteWd-1:0] rem_keep_o
);

  logic [2*DataWd-1:0] wide_data;
  logic [2*ByteWd-1:0] wide_keep;

  always_comb begin
    wide_data = {res_data_i, {DataWd{1'b0}}} |
                ({beat_data_i, {DataWd{1'b0}}} >> {shift_i, 3'b000});
    wide_keep = {res_keep_i, {ByteWd{1'b0}}} |
                ({beat_keep_i, {ByteWd{1'b0}}} >> shift_i);
  end

  assign merged_data_o = wide_data[2*DataWd-1 -: DataWd];
  assign rem_data_o    = wide_data[DataWd-1:0];
  assign merged_keep_o = wide_keep[2*ByteWd-1 -: ByteWd];
  assign rem_keep_o    = wide_keep[ByteWd-1:0];

endmodule

// File: rtl/data_extractor_stream.sv
// Strips a 1..DATA_BYTE_WD byte header from the front of each AXI-Stream packet.
// The header goes out as one right-justified beat on m00; the remaining bytes are realigned
// to full beats on m01. Byte order: MSB lane is first on the wire.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   cfg_hdr_bytes               header length n, sampled on each packet's first beat
//   s_axis_*                    packet input (tvalid/tdata/tkeep/tlast, tready out)
//   m00_axis_*                  header output (tvalid/tdata/tkeep, tready in)
//   m01_axis_*                  payload output (tvalid/tdata/tkeep/tlast, tready in)
//   err_short                   one-cycle pulse when a packet carried no payload
module data_extractor_stream
  import data_extractor_stream_pkg::*;
#(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned LEN_WD       = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LEN_WD-1:0]       cfg_hdr_bytes,
  input  logic                    s_axis_tvalid,
  input  logic [DATA_WD-1:0]      s_axis_tdata,
  input  logic [DATA_BYTE_WD-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic                    m00_axis_tvalid,
  output logic [DATA_WD-1:0]      m00_axis_tdata,
  output logic [DATA_BYTE_WD-1:0] m00_axis_tkeep,
  input  logic                    m00_axis_tready,
  output logic                    m01_axis_tvalid,
  output logic [DATA_WD-1:0]      m01_axis_tdata,
  output logic [DATA_BYTE_WD-1:0] m01_axis_tkeep,
  output logic                    m01_axis_tlast,
  input  logic                    m01_axis_tready,
  output logic                    err_short
);

  localparam logic [LEN_WD-1:0] WLen = LEN_WD'(DATA_BYTE_WD);

  ext_state_e st_q, st_d;

  logic [LEN_WD-1:0]       n_q, n_d;
  logic [DATA_WD-1:0]      res_data_q, res_data_d;
  logic [DATA_BYTE_WD-1:0] res_keep_q, res_keep_d;

  logic                    hdr_valid_q, hdr_valid_d;
  logic [DATA_WD-1:0]      hdr_data_q, hdr_data_d;
  logic [DATA_BYTE_WD-1:0] hdr_keep_q, hdr_keep_d;

  logic                    pay_valid_q, pay_valid_d;
  logic [DATA_WD-1:0]      pay_data_q, pay_data_d;
  logic [DATA_BYTE_WD-1:0] pay_keep_q, pay_keep_d;
  logic                    pay_last_q, pay_last_d;

  logic                    err_q, err_d;

  logic [LEN_WD-1:0]       cfg_n, n_cur, shift, beat_cnt, hdr_trim;
  logic [DATA_WD-1:0]      beat_data, res_in_data, merged_data, rem_data;
  logic [DATA_BYTE_WD-1:0] beat_keep, res_in_keep, merged_keep, rem_keep;
  logic                    hdr_free, pay_free, s_ready, s_acc, rem_empty;

  // Input normalisation: keep is forced contiguous MSB-aligned and dead lanes are zeroed so
  // the last payload beat carries zeros below its valid bytes.
  always_comb begin
    beat_cnt  = LEN_WD'(keep_to_count(MaxKeepWd'(s_axis_tkeep)));
    beat_keep = DATA_BYTE_WD'(count_to_msb_mask(keep_to_count(MaxKeepWd'(s_axis_tkeep)),
                                                DATA_BYTE_WD));
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
      beat_data[8*i +: 8] = beat_keep[i] ? s_axis_tdata[8*i +: 8] : 8'h00;
    end
  end

  always_comb begin
    cfg_n = ((cfg_hdr_bytes == '0) || (cfg_hdr_bytes > WLen)) ? WLen : cfg_hdr_bytes;
    // n is only taken from the config port on the first beat; afterwards it is frozen.
    n_cur = (st_q == StHdr) ? cfg_n : n_q;
    shift = WLen - n_cur;
    // The header beat is split with an empty residue.
    res_in_data = (st_q == StHdr) ? '0 : res_data_q;
    res_in_keep = (st_q == StHdr) ? '0 : res_keep_q;
    // A first beat shorter than n yields a header of only k bytes, still right-justified.
    hdr_trim  = (beat_cnt < n_cur) ? (n_cur - beat_cnt) : '0;
    rem_empty = (rem_keep == '0);
  end

  axis_byte_merge #(
    .DataWd(DATA_WD),
    .ByteWd(DATA_BYTE_WD),
    .ShWd  (LEN_WD)
  ) u_merge (
    .res_data_i   (res_in_data),
    .res_keep_i   (res_in_keep),
    .beat_data_i  (beat_data),
    .beat_keep_i  (beat_keep),
    .shift_i      (shift),
    .merged_data_o(merged_data),
    .merged_keep_o(merged_keep),
    .rem_data_o   (rem_data),
    .rem_keep_o   (rem_keep)
  );

  assign hdr_free = !hdr_valid_q || m00_axis_tready;
  assign pay_free = !pay_valid_q || m01_axis_tready;

  // Ready follows whichever output register the current state would load.
  always_comb begin
    s_ready = 1'b0;
    unique case (st_q)
      StHdr:   s_ready = hdr_free;
      StBody:  s_ready = pay_free;
      StFlush: s_ready = 1'b0;
      default: s_ready = 1'b0;
    endcase
  end

  assign s_acc = s_ready && s_axis_tvalid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= StHdr;
    end else begin
      st_q <= st_d;
    end
  end

  // Next-state logic.
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StHdr: begin
        if (s_acc) begin
          if (!s_axis_tlast)  st_d = StBody;
          else if (rem_empty) st_d = StHdr;
          else                st_d = StFlush;
        end
      end
      StBody: begin
        if (s_acc && s_axis_tlast) st_d = rem_empty ? StHdr : StFlush;
      end
      StFlush: begin
        if (pay_free) st_d = StHdr;
      end
      default: st_d = StHdr;
    endcase
  end

  // Output / datapath next-state logic.
  always_comb begin
    n_d         = n_q;
    res_data_d  = res_data_q;
    res_keep_d  = res_keep_q;
    hdr_valid_d = hdr_valid_q && !m00_axis_tready;
    hdr_data_d  = hdr_data_q;
    hdr_keep_d  = hdr_keep_q;
    pay_valid_d = pay_valid_q && !m01_axis_tready;
    pay_data_d  = pay_data_q;
    pay_keep_d  = pay_keep_q;
    pay_last_d  = pay_last_q;
    err_d       = 1'b0;
    unique case (st_q)
      StHdr: begin
        if (s_acc) begin
          n_d         = cfg_n;
          hdr_valid_d = 1'b1;
          hdr_data_d  = merged_data >> {hdr_trim, 3'b000};
          hdr_keep_d  = merged_keep >> hdr_trim;
          res_data_d  = rem_data;
          res_keep_d  = rem_keep;
          err_d       = s_axis_tlast && rem_empty;
        end
      end
      StBody: begin
        if (s_acc) begin
          pay_valid_d = 1'b1;
          pay_data_d  = merged_data;
          pay_keep_d  = merged_keep;
          pay_last_d  = s_axis_tlast && rem_empty;
          res_data_d  = rem_data;
          res_keep_d  = rem_keep;
        end
      end
      StFlush: begin
        if (pay_free) begin
          pay_valid_d = 1'b1;
          pay_data_d  = res_data_q;
          pay_keep_d  = res_keep_q;
          pay_last_d  = 1'b1;
          res_data_d  = '0;
          res_keep_d  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q         <= WLen;
      res_data_q  <= '0;
      res_keep_q  <= '0;
      hdr_valid_q <= 1'b0;
      hdr_data_q  <= '0;
      hdr_keep_q  <= '0;
      pay_valid_q <= 1'b0;
      pay_data_q  <= '0;
      pay_keep_q  <= '0;
      pay_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      n_q         <= n_d;
      res_data_q  <= res_data_d;
      res_keep_q  <= res_keep_d;
      hdr_valid_q <= hdr_valid_d;
      hdr_data_q  <= hdr_data_d;
      hdr_keep_q  <= hdr_keep_d;
      pay_valid_q <= pay_valid_d;
      pay_data_q  <= pay_data_d;
      pay_keep_q  <= pay_keep_d;
      pay_last_q  <= pay_last_d;
      err_q       <= err_d;
    end
  end

  assign s_axis_tready   = s_ready;
  assign m00_axis_tvalid = hdr_valid_q;
  assign m00_axis_tdata  = hdr_data_q;
  assign m00_axis_tkeep  = hdr_keep_q;
  assign m01_axis_tvalid = pay_valid_q;
  assign m01_axis_tdata  = pay_data_q;
  assign m01_axis_tkeep  = pay_keep_q;
  assign m01_axis_tlast  = pay_last_q;
  assign err_short       = err_q;

endmodule
